lsu_mem_align: RTL and testbench

- Load/store alignment unit between the core data port and the byte-enable data RAM (32-bit words, synchronous read, 1-cycle latency).
- Converts a byte address, access size and signedness into RAM word address, byte enables and lane-shifted write data.
- Splits misaligned accesses that cross a word boundary into two RAM accesses, then reassembles, shifts and extends read data.
- The RAM's own extension logic is bypassed: this block always drives word reads and does all extraction itself.

---
 rtl/lsu_mem_align.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_align.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_align.sv
// Load/store alignment unit: maps byte accesses onto a 32-bit byte-enable RAM,
// splitting word-crossing accesses into two RAM cycles and extracting load data.
module lsu_mem_align #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [31:0]   req_addr,
   input  logic [1:0]    req_size,
   input  logic          req_signed,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic          rsp_err,
   output logic [31:0]   rsp_rdata,
   output logic          ram_we,
   output logic [3:0]    ram_be,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_din,
   input  logic [31:0]   ram_dout,
   output logic          ram_read_signed,
   output logic [1:0]    ram_read_size
);
   typedef enum logic [2:0] {IDLE, A0, A1, CAP, RSP} state_t;

   localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

   state_t        state_q, state_d;
   logic          we_q, signed_q, err_q;
   logic [AW+1:0] addr_q;
   logic [1:0]    size_q;
   logic [31:0]   wdata_q, w0_q, rdata_q;

   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Error decision is made on the live request so an error skips the RAM entirely
   logic [7:0] req_be64;
   logic       req_split, req_err;
   assign req_be64  = {4'b0000, size_mask(req_size)} << req_addr[1:0];
   assign req_split = |req_be64[7:4];
   assign req_err   = (req_size == 2'b11) || (req_addr[31:AW+2] != '0) ||
                      (req_split && (req_addr[AW+1:2] == LAST_WORD));

   logic [1:0]    off;
   logic [3:0]    mask;
   logic [7:0]    be64;
   logic          split;
   logic [31:0]   wmask;
   logic [63:0]   wd64;
   logic [AW-1:0] word0, word1;
   assign off   = addr_q[1:0];
   assign mask  = size_mask(size_q);
   assign be64  = {4'b0000, mask} << off;
   assign split = |be64[7:4];
   assign wmask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
   assign wd64  = {32'b0, wdata_q & wmask} << {off, 3'b000};
   assign word0 = addr_q[AW+1:2];
   assign word1 = word0 + 1'b1;

   // In CAP the RAM output holds the last word read; for split loads w0 was captured in A1
   logic [31:0] cap_w0, load_raw, load_val;
   logic [63:0] pair;
   assign cap_w0   = split ? w0_q : ram_dout;
   assign pair     = {ram_dout, cap_w0};
   assign load_raw = pair[{off, 3'b000} +: 32];

   always_comb begin
      load_val = load_raw;
      case (size_q)
         2'b00:   load_val = {{24{signed_q & load_raw[7]}}, load_raw[7:0]};
         2'b01:   load_val = {{16{signed_q & load_raw[15]}}, load_raw[15:0]};
         default: load_val = load_raw;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         size_q   <= 2'b00;
         wdata_q  <= '0;
         w0_q     <= '0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_valid) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            err_q    <= req_err;
            addr_q   <= req_addr[AW+1:0];
            size_q   <= req_size;
            wdata_q  <= req_wdata;
         end
         if (state_q == A1 && !we_q) w0_q <= ram_dout;
         if (state_q == CAP) rdata_q <= load_val;
      end
   end

   // RAM controls are decoded from state so a reset drops the write strobe at once
   always_comb begin
      state_d  = state_q;
      ram_we   = 1'b0;
      ram_be   = 4'b0000;
      ram_addr = word0;
      ram_din  = wd64[31:0];
      case (state_q)
         IDLE: if (req_valid) state_d = req_err ? RSP : A0;
         A0: begin
            ram_we  = we_q;
            ram_be  = be64[3:0];
            state_d = split ? A1 : (we_q ? RSP : CAP);
         end
         A1: begin
            ram_we   = we_q;
            ram_be   = be64[7:4];
            ram_addr = word1;
            ram_din  = wd64[63:32];
            state_d  = we_q ? RSP : CAP;
         end
         CAP:     state_d = RSP;
         RSP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign req_ready       = (state_q == IDLE);
   assign rsp_valid       = (state_q == RSP);
   assign rsp_err         = rsp_valid & err_q;
   assign rsp_rdata       = rdata_q;
   assign ram_read_signed = 1'b0;
   assign ram_read_size   = 2'b10;
endmodule

// File: tb/tb_lsu_mem_align.sv
// Self-checking bench: byte-level reference memory predicts latency, RAM traffic
// and load results for directed and random accesses.
module tb_lsu_mem_align;
   localparam int DEPTH  = 4096;
   localparam int AW     = 12;
   localparam int NBYTES = DEPTH * 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
   logic [31:0]   req_addr = '0, req_wdata = '0;
   logic [1:0]    req_size = 2'b00;
   logic          req_ready, rsp_valid, rsp_err, ram_we, ram_read_signed;
   logic [31:0]   rsp_rdata, ram_din, ram_dout;
   logic [3:0]    ram_be;
   logic [AW-1:0] ram_addr;
   logic [1:0]    ram_read_size;

   always #5 clk = ~clk;

   lsu_mem_align #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout), .ram_read_signed(ram_read_signed),
      .ram_read_size(ram_read_size)
   );

   // Byte-enable RAM with one-cycle synchronous read
   logic [31:0] ram_mem [DEPTH] = '{default: '0};
   always @(posedge clk) begin
      for (int j = 0; j < 4; j++)
         if (ram_we && ram_be[j]) ram_mem[ram_addr][8*j +: 8] <= ram_din[8*j +: 8];
      ram_dout <= ram_mem[ram_addr];
   end

   // Reference memory, byte addressed
   logic [7:0] ref_mem [NBYTES] = '{default: '0};

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Expectation of the in-flight transaction
   bit          busy = 0;
   bit          e_we, e_err, e_split;
   int unsigned e_addr;
   int          e_n, e_lat, e_nacc, cyc_n;
   logic [31:0] e_wdata, e_rdata;
   logic [31:0] last_rdata = '0;
   bit          last_err = 0;
   int          rsp_cyc = 0, acc_cyc = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Compare process
   int unsigned cw, cb;
   logic [3:0]  ebe;
   logic [31:0] edin, emask;
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy) begin
            cyc_n = cyc_n + 1;
            if (!e_err && cyc_n <= e_nacc) begin
               cw = e_addr / 4 + cyc_n - 1;
               ebe = '0; edin = '0; emask = '0;
               for (int j = 0; j < 4; j++) begin
                  cb = cw * 4 + j;
                  if (cb >= e_addr && cb < e_addr + e_n) begin
                     ebe[j] = 1'b1;
                     emask[8*j +: 8] = 8'hFF;
                     edin[8*j +: 8] = e_wdata[8*(cb - e_addr) +: 8];
                  end
               end
               chk("ram_addr", 32'(ram_addr), 32'(cw[AW-1:0]));
               chk("ram_be", 32'(ram_be), 32'(ebe));
               chk("ram_we", 32'(ram_we), 32'(e_we));
               if (e_we) chk("ram_din", ram_din & emask, edin);
            end else begin
               chk("ram_we_idle", 32'(ram_we), 0);
               chk("ram_be_idle", 32'(ram_be), 0);
            end
            chk("req_ready_busy", 32'(req_ready), 0);
            if (cyc_n < e_lat) begin
               chk("rsp_valid_early", 32'(rsp_valid), 0);
            end else begin
               chk("rsp_valid", 32'(rsp_valid), 1);
               chk("rsp_err", 32'(rsp_err), 32'(e_err));
               if (!e_err && !e_we) last_rdata = e_rdata;
               chk("rsp_rdata", rsp_rdata, last_rdata);
               if (e_we && !e_err)
                  for (int i = 0; i < e_n; i++) ref_mem[e_addr + i] = e_wdata[8*i +: 8];
               last_err = rsp_err;
               rsp_cyc  = cyc_cnt;
               busy     = 0;
            end
         end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 0);
            chk("req_ready_idle", 32'(req_ready), 1);
            chk("ram_we_noreq", 32'(ram_we), 0);
            chk("rsp_rdata_hold", rsp_rdata, last_rdata);
         end
      end
   end

   // Present a request, wait for acceptance and publish the model's expectation
   task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wd, input bit hold);
      int waitc;
      int n;
      int unsigned a;
      logic [31:0] v;
      @(negedge clk);
      req_we = we; req_addr = addr; req_size = size; req_signed = sgn;
      req_wdata = wd; req_valid = 1'b1;
      waitc = 0;
      while (!req_ready && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      if (!req_ready) begin
         chk("ready_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
      acc_cyc = cyc_cnt;
      a = addr;
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      e_split = ((a % 4) + n) > 4;
      e_err   = (size == 2'd3) || (a >= NBYTES) || (e_split && (a / 4 == DEPTH - 1));
      e_lat   = e_err ? 1 : (we ? (e_split ? 3 : 2) : (e_split ? 4 : 3));
      e_nacc  = e_split ? 2 : 1;
      e_we = we; e_addr = a; e_n = n; e_wdata = wd;
      e_rdata = '0;
      if (!e_err && !we) begin
         v = '0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
         if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
         e_rdata = v;
      end
      cyc_n = 0;
      busy  = 1;
   endtask

   task automatic wait_done();
      int w = 0;
      while (busy && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (busy) begin
         chk("done_timeout", 0, 1);
         busy = 0;
      end
   endtask

   logic [31:0] ra;
   int r;
   initial begin
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_be", 32'(ram_be), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_din", ram_din, 0);
      chk("rst_ready", 32'(req_ready), 1);
      chk("ram_read_size", 32'(ram_read_size), 2);
      chk("ram_read_signed", 32'(ram_read_signed), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Aligned word store and load
      issue(1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0);
      @(negedge clk);
      chk("lit_st_be", 32'(ram_be), 32'hF);
      chk("lit_st_addr", 32'(ram_addr), 4);
      wait_done();
      issue(0, 32'h10, 2'b10, 0, 32'h0, 0);
      @(negedge clk);
      chk("lit_ld_be", 32'(ram_be), 32'hF);
      wait_done();
      chk("lit_ld_word", rsp_rdata, 32'hDEADBEEF);

      // Byte store, signed and unsigned byte loads
      issue(1, 32'h23, 2'b00, 0, 32'h00000080, 0);
      @(negedge clk);
      chk("lit_byte_be", 32'(ram_be), 32'b1000);
      wait_done();
      issue(0, 32'h23, 2'b00, 1, 32'h0, 0);
      wait_done();
      chk("lit_lb_signed", rsp_rdata, 32'hFFFFFF80);
      issue(0, 32'h23, 2'b00, 0, 32'h0, 0);
      wait_done();
      chk("lit_lb_unsigned", rsp_rdata, 32'h00000080);

      // Split word store then loads
      issue(1, 32'h06, 2'b10, 0, 32'h11223344, 0);
      @(negedge clk);
      chk("lit_s0_be", 32'(ram_be), 32'b1100);
      chk("lit_s0_addr", 32'(ram_addr), 1);
      chk("lit_s0_din", 32'(ram_din[31:16]), 32'h3344);
      @(negedge clk);
      chk("lit_s1_be", 32'(ram_be), 32'b0011);
      chk("lit_s1_addr", 32'(ram_addr), 2);
      chk("lit_s1_din", 32'(ram_din[15:0]), 32'h1122);
      wait_done();
      issue(0, 32'h06, 2'b10, 0, 32'h0, 0);
      wait_done();
      chk("lit_split_lw", rsp_rdata, 32'h11223344);
      issue(0, 32'h07, 2'b01, 0, 32'h0, 0);
      wait_done();
      chk("lit_lhu", rsp_rdata, 32'h00002233);

      // Errors
      issue(1, 32'h10, 2'b11, 0, 32'h12345678, 0);
      wait_done();
      chk("lit_err_size", 32'(last_err), 1);
      issue(0, NBYTES, 2'b10, 0, 32'h0, 0);
      wait_done();
      chk("lit_err_range", 32'(last_err), 1);
      issue(1, NBYTES - 2, 2'b10, 0, 32'hCAFEF00D, 0);
      wait_done();
      chk("lit_err_lastsplit", 32'(last_err), 1);

      // Back-to-back with req_valid held high
      issue(0, 32'h10, 2'b10, 0, 32'h0, 1);
      issue(0, 32'h06, 2'b10, 0, 32'h0, 0);
      chk("b2b_accept_cycle", 32'(acc_cyc), 32'(rsp_cyc + 2));
      wait_done();

      // Reset during A1 of a split store
      issue(1, 32'h106, 2'b10, 0, 32'hA1B2C3D4, 0);
      @(negedge clk);
      @(negedge clk);
      #2;
      chk("pre_rst_we", 32'(ram_we), 1);
      rst_n = 1'b0;
      busy  = 0;
      #1;
      chk("mid_rst_we", 32'(ram_we), 0);
      chk("mid_rst_be", 32'(ram_be), 0);
      chk("mid_rst_addr", 32'(ram_addr), 0);
      chk("mid_rst_din", ram_din, 0);
      chk("mid_rst_valid", 32'(rsp_valid), 0);
      chk("mid_rst_rdata", rsp_rdata, 0);
      chk("mid_rst_ready", 32'(req_ready), 1);
      last_rdata = '0;
      ref_mem[32'h106] = 8'hD4;
      ref_mem[32'h107] = 8'hC3;
      @(negedge clk);
      rst_n = 1'b1;
      issue(0, 32'h104, 2'b10, 0, 32'h0, 0);
      wait_done();
      issue(0, 32'h108, 2'b10, 0, 32'h0, 0);
      wait_done();
      chk("lit_word1_untouched", rsp_rdata, 32'h00000000);

      // Random traffic
      for (int t = 0; t < 400; t++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         r = $urandom_range(0, 9);
         if (r < 6)      ra = $urandom_range(0, 127);
         else if (r < 8) ra = NBYTES - $urandom_range(1, 8);
         else if (r < 9) ra = NBYTES + $urandom_range(0, 7);
         else            ra = $urandom;
         issue(1'($urandom_range(0, 1)), ra,
               ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), $urandom, 0);
      end
      wait_done();
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
